// File: rtl/wb_axi4lite_bridge.sv
// wb_axi4lite_bridge: Wishbone B4 pipelined slave to AXI4-Lite master.
// One transaction in flight; each accepted strobe becomes exactly one AXI
// write or read and completes with a single-cycle ack (or err) pulse.
// Optional feature macro: WB2AXI_ERR_EN (non-OKAY responses give wb_err_o).
//
// Handshake rule: a transfer happens on a rising aclk edge where both valid
// and ready are high; valids here are registered and never look at ready
// combinationally, and once raised they stay high until their handshake.
module wb_axi4lite_bridge #(
    parameter int         ADDR_WIDTH = 5,
    parameter logic [2:0] PROT       = 3'b000
) (
    input  logic                  aclk,
    input  logic                  areset_n,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_we_i,
    input  logic [ADDR_WIDTH-3:0] wb_adr_i,
    input  logic [31:0]           wb_dat_i,
    input  logic [3:0]            wb_sel_i,
    output logic                  wb_stall_o,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    output logic [31:0]           wb_dat_o,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [ADDR_WIDTH-3:0] awaddr,
    output logic [2:0]            awprot,
    output logic                  wvalid,
    input  logic                  wready,
    output logic [31:0]           wdata,
    output logic [3:0]            wstrb,
    input  logic                  bvalid,
    output logic                  bready,
    input  logic [1:0]            bresp,
    output logic                  arvalid,
    input  logic                  arready,
    output logic [ADDR_WIDTH-3:0] araddr,
    output logic [2:0]            arprot,
    input  logic                  rvalid,
    output logic                  rready,
    input  logic [31:0]           rdata,
    input  logic [1:0]            rresp
);

    typedef enum logic [1:0] {IDLE, WR, RD, RESP} state_t;

    state_t                state, state_d;
    logic [ADDR_WIDTH-3:0] adr_q, adr_d;
    logic [31:0]           dat_q, dat_d;
    logic [3:0]            sel_q, sel_d;
    logic                  abort_q, abort_d;
    logic                  aw_q, aw_d;
    logic                  w_q, w_d;
    logic                  ar_q, ar_d;
    logic [1:0]            resp_q, resp_d;
    logic [31:0]           rd_q, rd_d;

    // State and datapath registers; reset drops every valid at once.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state   <= IDLE;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            abort_q <= 1'b0;
            aw_q    <= 1'b0;
            w_q     <= 1'b0;
            ar_q    <= 1'b0;
            resp_q  <= 2'b00;
            rd_q    <= '0;
        end else begin
            state   <= state_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            abort_q <= abort_d;
            aw_q    <= aw_d;
            w_q     <= w_d;
            ar_q    <= ar_d;
            resp_q  <= resp_d;
            rd_q    <= rd_d;
        end
    end

    // Next-state logic: accept in IDLE, track channel completion, latch response.
    always_comb begin
        state_d = state;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        abort_d = abort_q;
        aw_d    = aw_q;
        w_d     = w_q;
        ar_d    = ar_q;
        resp_d  = resp_q;
        rd_d    = rd_q;
        case (state)
            IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    adr_d   = wb_adr_i;
                    dat_d   = wb_dat_i;
                    sel_d   = wb_sel_i;
                    abort_d = 1'b0;
                    if (wb_we_i) begin
                        aw_d    = 1'b1;
                        w_d     = 1'b1;
                        state_d = WR;
                    end else begin
                        ar_d    = 1'b1;
                        state_d = RD;
                    end
                end
            end
            WR: begin
                if (aw_q && awready) aw_d = 1'b0;
                if (w_q && wready)   w_d  = 1'b0;
                if (!wb_cyc_i)       abort_d = 1'b1;
                // A response ends the write even if the slave skipped AW/W.
                if (bvalid) begin
                    aw_d    = 1'b0;
                    w_d     = 1'b0;
                    resp_d  = bresp;
                    state_d = RESP;
                end
            end
            RD: begin
                if (ar_q && arready) ar_d = 1'b0;
                if (!wb_cyc_i)       abort_d = 1'b1;
                if (rvalid) begin
                    ar_d    = 1'b0;
                    resp_d  = rresp;
                    rd_d    = rdata;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign wb_stall_o = (state != IDLE);
    assign wb_dat_o   = rd_q;
    assign awvalid    = aw_q;
    assign wvalid     = w_q;
    assign arvalid    = ar_q;
    assign awaddr     = adr_q;
    assign araddr     = adr_q;
    assign wdata      = dat_q;
    assign wstrb      = sel_q;
    assign awprot     = PROT;
    assign arprot     = PROT;
    assign bready     = (state == WR);
    assign rready     = (state == RD);

`ifdef WB2AXI_ERR_EN
    assign wb_ack_o = (state == RESP) && !abort_q && (resp_q == 2'b00);
    assign wb_err_o = (state == RESP) && !abort_q && (resp_q != 2'b00);
`else
    // Response code is latched but ignored when error reporting is off.
    logic unused_resp;
    assign unused_resp = ^resp_q;
    assign wb_ack_o    = (state == RESP) && !abort_q;
    assign wb_err_o    = 1'b0;
`endif

endmodule
